// File: rtl/tagged_sq_pipe.sv
// Two-stage valid/ready pipeline: saturated per-component squares, then saturated |d|^2.
// Optional output-transfer statistics are compiled in with `define TAGGED_SQ_STATS_EN.
module tagged_sq_pipe #(
  parameter int WIDTH    = 32,
  parameter int Q_BITS   = 16,
  parameter int TAG_SIZE = 64,
  parameter int STAT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef TAGGED_SQ_STATS_EN
  input  logic                stat_clr,
  output logic [STAT_W-1:0]   stat_beats,
  output logic [STAT_W-1:0]   stat_sats,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TAG_SIZE-1:0] in_tag,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_y,
  input  logic [WIDTH-1:0]    in_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_SIZE-1:0] out_tag,
  output logic [WIDTH-1:0]    out_sq_x,
  output logic [WIDTH-1:0]    out_sq_y,
  output logic [WIDTH-1:0]    out_sq_z,
  output logic [WIDTH-1:0]    out_mag2,
  output logic                out_sat
);

  localparam logic [WIDTH-1:0] SQ_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic s1_adv;
  logic s2_adv;

  logic [WIDTH-1:0] comp [3];
  logic [WIDTH-1:0] sq_next [3];
  logic [2:0]       sat_next;

  logic                s1_valid_reg;
  logic [TAG_SIZE-1:0] s1_tag_reg;
  logic [WIDTH-1:0]    s1_sq_reg [3];
  logic [2:0]          s1_sat_reg;

  logic                out_valid_reg;
  logic [TAG_SIZE-1:0] out_tag_reg;
  logic [WIDTH-1:0]    out_sq_reg [3];
  logic [WIDTH-1:0]    out_mag2_reg;
  logic                out_sat_reg;

  logic [WIDTH+1:0] sum_next;
  logic             sum_sat;
  logic [WIDTH-1:0] mag2_next;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  assign comp[0] = in_x;
  assign comp[1] = in_y;
  assign comp[2] = in_z;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sq
      logic signed [2*WIDTH-1:0] ext;
      logic signed [2*WIDTH-1:0] product;
      logic                      unused_low;
      assign ext        = {{WIDTH{comp[gi][WIDTH-1]}}, comp[gi]};
      assign product    = ext * ext;
      assign unused_low = ^product[Q_BITS-1:0];
      // Any set bit at or above the result's sign position means the Q-format square overflowed.
      assign sat_next[gi] = |product[2*WIDTH-1:WIDTH+Q_BITS-1];
      assign sq_next[gi]  = sat_next[gi] ? SQ_MAX : product[WIDTH+Q_BITS-1:Q_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_tag_reg   <= '0;
      s1_sat_reg   <= '0;
      for (int i = 0; i < 3; i++) s1_sq_reg[i] <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_tag_reg <= in_tag;
        s1_sat_reg <= sat_next;
        for (int i = 0; i < 3; i++) s1_sq_reg[i] <= sq_next[i];
      end
    end
  end

  // Squares are non-negative, so the two guard bits make the sum exact.
  assign sum_next  = {2'b00, s1_sq_reg[0]} + {2'b00, s1_sq_reg[1]} + {2'b00, s1_sq_reg[2]};
  assign sum_sat   = sum_next > {2'b00, SQ_MAX};
  assign mag2_next = sum_sat ? SQ_MAX : sum_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_tag_reg   <= '0;
      out_mag2_reg  <= '0;
      out_sat_reg   <= 1'b0;
      for (int i = 0; i < 3; i++) out_sq_reg[i] <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_tag_reg  <= s1_tag_reg;
        out_mag2_reg <= mag2_next;
        out_sat_reg  <= (|s1_sat_reg) || sum_sat;
        for (int i = 0; i < 3; i++) out_sq_reg[i] <= s1_sq_reg[i];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_tag   = out_tag_reg;
  assign out_sq_x  = out_sq_reg[0];
  assign out_sq_y  = out_sq_reg[1];
  assign out_sq_z  = out_sq_reg[2];
  assign out_mag2  = out_mag2_reg;
  assign out_sat   = out_sat_reg;

`ifdef TAGGED_SQ_STATS_EN
  logic                out_fire;
  logic [STAT_W-1:0]   stat_beats_reg;
  logic [STAT_W-1:0]   stat_sats_reg;

  assign out_fire = out_valid_reg && out_ready;

  // Clear wins over a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_reg <= '0;
      stat_sats_reg  <= '0;
    end else if (stat_clr) begin
      stat_beats_reg <= '0;
      stat_sats_reg  <= '0;
    end else if (out_fire) begin
      if (stat_beats_reg != '1) stat_beats_reg <= stat_beats_reg + 1'b1;
      if (out_sat_reg && (stat_sats_reg != '1)) stat_sats_reg <= stat_sats_reg + 1'b1;
    end
  end

  assign stat_beats = stat_beats_reg;
  assign stat_sats  = stat_sats_reg;
`endif

endmodule

// File: tb/tb_tagged_sq_pipe.sv
// Bench for tagged_sq_pipe: vector table, backpressure/reset sequences and a randomized
// scoreboard against an arithmetic model. Define TAGGED_SQ_STATS_EN to cover the counters.
module tb_tagged_sq_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_SIZE = 64;
  localparam int STAT_W = 32;
  localparam longint MAXV = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [TAG_SIZE-1:0] in_tag = '0;
  logic [WIDTH-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [TAG_SIZE-1:0] out_tag;
  logic [WIDTH-1:0] out_sq_x, out_sq_y, out_sq_z, out_mag2;
  logic out_sat;
`ifdef TAGGED_SQ_STATS_EN
  logic stat_clr = 1'b0;
  logic [STAT_W-1:0] stat_beats, stat_sats;
`endif

  int checks = 0;
  int errors = 0;

  tagged_sq_pipe #(.WIDTH(WIDTH), .Q_BITS(16), .TAG_SIZE(TAG_SIZE), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef TAGGED_SQ_STATS_EN
    .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_sats(stat_sats),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_sq_x(out_sq_x), .out_sq_y(out_sq_y), .out_sq_z(out_sq_z),
    .out_mag2(out_mag2), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_out(input logic [63:0] tag, input logic [31:0] sx,
      input logic [31:0] sy, input logic [31:0] sz, input logic [31:0] mag, input logic sat);
    return {63'd0, tag, sx, sy, sz, mag, sat};
  endfunction

  // Reference: real-valued square in Q16, clamp to the largest positive word, then clamp the sum.
  function automatic logic [255:0] model(input logic [63:0] tag, input logic [31:0] x,
      input logic [31:0] y, input logic [31:0] z);
    longint c[3];
    longint sq[3];
    longint sum;
    logic sat;
    logic [31:0] r[3];
    logic [31:0] m;
    c[0] = longint'($signed(x));
    c[1] = longint'($signed(y));
    c[2] = longint'($signed(z));
    sat = 1'b0;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      sq[i] = (c[i] * c[i]) >>> 16;
      if (sq[i] > MAXV) begin
        sq[i] = MAXV;
        sat = 1'b1;
      end
      sum += sq[i];
      r[i] = sq[i][31:0];
    end
    if (sum > MAXV) begin
      sum = MAXV;
      sat = 1'b1;
    end
    m = sum[31:0];
    return pack_out(tag, r[0], r[1], r[2], m, sat);
  endfunction

  function automatic logic [255:0] dut_out();
    return pack_out(out_tag, out_sq_x, out_sq_y, out_sq_z, out_mag2, out_sat);
  endfunction

  // Scoreboard monitor: sampled on the falling edge, when all driven inputs are settled.
  logic [255:0] exp_q[$];
  logic [63:0]  got_q[$];
  logic         hold_pending = 1'b0;
  logic [255:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("stall_hold", dut_out(), held);
      check("in_ready", {255'd0, in_ready}, {255'd0, (exp_q.size() < 2) || out_ready});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {255'd0, out_valid}, 256'd0);
        end else begin
          check("out_beat", dut_out(), exp_q.pop_front());
          got_q.push_back(out_tag);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_tag, in_x, in_y, in_z));
      hold_pending = out_valid && !out_ready;
      held = dut_out();
    end
  end

  typedef struct {
    logic [31:0] x, y, z;
    logic [63:0] tag;
    logic [31:0] sx, sy, sz, mag;
    logic        sat;
  } vec_t;
  vec_t vecs[8];

  task automatic drive(input logic [63:0] tag, input logic [31:0] x, input logic [31:0] y,
      input logic [31:0] z);
    in_valid = 1'b1; in_tag = tag; in_x = x; in_y = y; in_z = z;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] b[6];
    b[0] = 32'h8000_0000; b[1] = 32'h7FFF_FFFF; b[2] = 32'h00B5_0000;
    b[3] = 32'hFF4B_0000; b[4] = 32'h00B6_0000; b[5] = 32'h006E_0000;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 32'h0007_FFFF)) - 32'h0004_0000;
      2: return b[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
    endcase
  endfunction

  initial begin
    int idx;
    logic saw_drop;

    vecs[0] = '{32'h0002_0000, 32'hFFFE_8000, 32'h0, 64'hA5,
                32'h0004_0000, 32'h0002_4000, 32'h0, 32'h0006_4000, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 64'h11,
                32'h0001_0000, 32'h0004_0000, 32'h0004_0000, 32'h0009_0000, 1'b0};
    vecs[2] = '{32'h0100_0000, 32'h0, 32'h0, 64'h22,
                32'h7FFF_FFFF, 32'h0, 32'h0, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{32'h006E_0000, 32'h006E_0000, 32'h006E_0000, 64'h33,
                32'h2F44_0000, 32'h2F44_0000, 32'h2F44_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 64'hDEAD_BEEF_0000_0044,
                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{32'h00B5_0000, 32'h0, 32'h0, 64'h55,
                32'h7FF9_0000, 32'h0, 32'h0, 32'h7FF9_0000, 1'b0};
    vecs[6] = '{32'h0, 32'hFF4A_0000, 32'h0, 64'h66,
                32'h0, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 64'h77,
                32'h0, 32'h0000_4000, 32'h0, 32'h0000_4000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {255'd0, out_valid}, 256'd0);
    check("reset_data", dut_out(), 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {255'd0, in_ready}, {255'd0, 1'b1});

    // Directed vectors, one at a time, checking the 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].tag, vecs[i].x, vecs[i].y, vecs[i].z);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("latency_1", {255'd0, out_valid}, 256'd0);
      @(posedge clk); #1;
      check("latency_2", {255'd0, out_valid}, {255'd0, 1'b1});
      check("vector", dut_out(),
            pack_out(vecs[i].tag, vecs[i].sx, vecs[i].sy, vecs[i].sz, vecs[i].mag, vecs[i].sat));
    end
    drain();

    // Backpressure: tags 1..6 with out_ready low in cycles 3..7
    got_q.delete();
    idx = 1;
    saw_drop = 1'b0;
    for (int k = 0; k < 60 && (idx <= 6 || exp_q.size() != 0); k++) begin
      @(posedge clk); #1;
      out_ready = !(k >= 3 && k <= 7);
      if (idx <= 6) drive(64'(idx), 32'(idx) << 16, 32'h0001_0000, 32'h0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (!in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_in_ready_drop", {255'd0, saw_drop}, {255'd0, 1'b1});
    check("bp_remaining", exp_q.size(), 0);
    check("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check("bp_tag_order", got_q[i], 256'(i + 1));

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) drive({$urandom, $urandom}, rnd_word(), rnd_word(), rnd_word());
      else in_valid = 1'b0;
    end
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(64'hF1, 32'h0003_0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(64'hF2, 32'h0004_0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_full", {255'd0, out_valid}, {255'd0, 1'b1});
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_valid", {255'd0, out_valid}, 256'd0);
    check("midreset_data", dut_out(), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("no_stale_beat", {255'd0, out_valid}, 256'd0);
    end
    drive(64'hF3, 32'h0001_0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

`ifdef TAGGED_SQ_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_idle", {stat_beats, stat_sats}, 256'd0);
    for (int i = 0; i < 4; i++) begin
      idx = (i == 3) ? 5 : i;
      drive(vecs[idx].tag, vecs[idx].x, vecs[idx].y, vecs[idx].z);
      @(posedge clk); #1;
    end
    drain();
    check("stat_beats", stat_beats, 256'd4);
    check("stat_sats", stat_sats, 256'd1);
    drive(vecs[2].tag, vecs[2].x, vecs[2].y, vecs[2].z);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_cycle_valid", {255'd0, out_valid}, {255'd0, 1'b1});
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_priority", {stat_beats, stat_sats}, 256'd0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/tagged_sq_pipe.md
Name: tagged_sq_pipe

Overview:
- Pipelined, back-pressurable successor of the single-cycle direction-squaring stage in the ray-normalization path.
- Accepts a tagged fixed-point direction (x, y, z) and produces:
  - per-component saturated squares;
  - the saturated squared magnitude |d|^2;
  - the tag, passed through unchanged.
- Sits between ray generation and the reciprocal-sqrt/normalize unit.
- Uses a valid/ready handshake on both sides so a stalled normalizer never drops rays.

Parameters:
- WIDTH, 32, signed fixed-point word width of each component and result.
- Q_BITS, 16, fractional bits (Q(WIDTH-Q_BITS-1).Q_BITS).
- TAG_SIZE, 64, width of the ray tag carried alongside the data.
- STAT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_tag  in  TAG_SIZE  ray tag.
- in_x, in_y, in_z  in  WIDTH each  signed direction components.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_tag  out  TAG_SIZE  tag of the output beat.
- out_sq_x, out_sq_y, out_sq_z  out  WIDTH each  saturated squares.
- out_mag2  out  WIDTH  saturated x^2+y^2+z^2.
- out_sat  out  1  set if any square or the sum saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits clear; out_valid=0;
  - all data outputs, out_sat and stage registers = 0;
  - in_ready=1 from the first cycle after reset deassertion.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage S1 (registered):
  - product = comp*comp as a 2*WIDTH signed value;
  - truncate: sq = product[WIDTH+Q_BITS-1:Q_BITS];
  - saturate: if product[2*WIDTH-1:WIDTH+Q_BITS-1] != 0, sq = 2^(WIDTH-1)-1 and the per-component sat bit is set;
  - -2^(WIDTH-1) input squares to a positive value and saturates normally;
  - tag is registered with the data.
- Stage S2 (registered):
  - sum = three S1 squares added in WIDTH+2 bits;
  - if sum > 2^(WIDTH-1)-1, out_mag2 = 2^(WIDTH-1)-1 and sum-sat is set;
  - out_sat = OR of the three component sat bits and sum-sat;
  - squares and tag are forwarded unchanged.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput: 1 beat/cycle.
- Flow control:
  - S2 advances when !out_valid || out_ready;
  - S1 advances when !s1_valid || S2 advances;
  - in_ready = !s1_valid || S2 advances (combinational from out_ready; no combinational path from in_valid to in_ready).
- Stall: while out_valid && !out_ready, every out_* signal is held bit-stable. At most 2 beats are in flight; no beat is dropped or duplicated.
- Simultaneous events:
  - input transfer and output transfer in the same cycle with both stages full: the pipeline shifts and in_ready stays 1;
  - in_valid is ignored whenever in_ready=0.
- Reset mid-operation: in-flight beats are discarded. No output transfer occurs until new inputs arrive.
- Ordering: output beats are in strict input order; tags are never reordered.

Optional Feature:
- Macro: TAGGED_SQ_STATS_EN.
- With the macro defined, additional ports are present:
  - stat_clr in 1;
  - stat_beats out STAT_W, counts output transfers;
  - stat_sats out STAT_W, counts output transfers with out_sat=1.
- Counter rules:
  - both counters are 0 on reset;
  - stat_clr clears them synchronously and has priority over an increment in the same cycle;
  - counters stick at all-ones and do not wrap.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- WIDTH=32, Q_BITS=16:
  - Inputs: x=0x0002_0000, y=0xFFFE_8000 (-1.5), z=0, tag=0xA5, out_ready=1.
  - Two cycles later: out_sq_x=0x0004_0000, out_sq_y=0x0002_4000, out_sq_z=0, out_tag=0xA5, out_sat=0.
- (1.0, 2.0, 2.0) -> out_mag2=0x0009_0000, out_sat=0.
- Overflow cases:
  - x=0x0100_0000 (256.0) -> out_sq_x=0x7FFF_FFFF, out_sat=1.
  - x=y=z=0x006E_0000 (110.0) -> each sq=0x2F44_0000, out_mag2=0x7FFF_FFFF, out_sat=1.
- Backpressure:
  - Stream 6 beats with tags 1..6, out_ready low for cycles 3-7.
  - in_ready drops after 2 beats are held; outputs stay stable during the stall.
  - All 6 tags emerge in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, outputs=0, no stale beat after release.
- With TAGGED_SQ_STATS_EN:
  - 4 beats, 1 saturating -> stat_beats=4, stat_sats=1.
  - Pulse stat_clr in the same cycle as an output transfer -> both counters read 0.
